// File: rtl/nibble_serial_exec_unit.sv
// Bit-serial (nibble-per-clock) Y86 OPq execute unit with condition codes.
// A 4-bit add/sub/logic slice walks the operands from LSB to MSB; the
// condition codes are updated from the finished result and feed the
// jXX/cmovXX condition evaluator.
module nibble_serial_exec_unit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  input  logic             set_cc,
  input  logic [3:0]       cond_fn,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] val_e,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cnd
);

  localparam int unsigned NIB   = 4;
  localparam int unsigned STEPS = WIDTH / NIB;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  // Elaboration-time guard on the operand width.
  if ((WIDTH % NIB) != 0 || WIDTH < 2 * NIB) begin : g_width_check
    $error("nibble_serial_exec_unit: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               accept_c;
  logic               last_c;

  logic [WIDTH-1:0]   a_sh_q, b_sh_q;
  logic [WIDTH-1:0]   acc_q;
  logic [1:0]         op_q;
  logic               set_cc_q;
  logic               a_msb_q, b_msb_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [NIB-1:0]     a_nib_c, b_nib_c, a_eff_c, nib_c;
  logic [NIB:0]       sum_c;
  logic               cout_c;
  logic [WIDTH-1:0]   result_c;
  logic               of_c;

  // Next-state logic and accept/last-step strobes.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = (ifun > 4'd3) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // 4-bit ALU slice on the low nibble of the shifting operands.
  always_comb begin
    a_nib_c = a_sh_q[NIB-1:0];
    b_nib_c = b_sh_q[NIB-1:0];
    a_eff_c = (op_q == OP_SUB) ? ~a_nib_c : a_nib_c;
    sum_c   = {1'b0, b_nib_c} + {1'b0, a_eff_c} + {NIB'(0), carry_q};
    nib_c   = sum_c[NIB-1:0];
    cout_c  = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        nib_c  = sum_c[NIB-1:0];
        cout_c = sum_c[NIB];
      end
      OP_AND: nib_c = b_nib_c & a_nib_c;
      OP_XOR: nib_c = b_nib_c ^ a_nib_c;
      default: nib_c = sum_c[NIB-1:0];
    endcase
    result_c = {nib_c, acc_q[WIDTH-1:NIB]};
  end

  // Signed overflow of the finished result from the operand sign bits.
  always_comb begin
    of_c = 1'b0;
    case (op_q)
      OP_ADD:  of_c = (a_msb_q == b_msb_q) && (result_c[WIDTH-1] != b_msb_q);
      OP_SUB:  of_c = (a_msb_q != b_msb_q) && (result_c[WIDTH-1] != b_msb_q);
      default: of_c = 1'b0;
    endcase
  end

  // State, datapath, result and condition-code registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      val_e    <= '0;
      zf       <= 1'b1;
      sf       <= 1'b0;
      of       <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      op_q     <= OP_ADD;
      set_cc_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      ready   <= (state_d == IDLE);
      done    <= (state_d == DONE);
      err     <= (state_d == DONE) && (state_q == IDLE);

      if (accept_c) begin
        a_sh_q   <= val_a;
        b_sh_q   <= val_b;
        a_msb_q  <= val_a[WIDTH-1];
        b_msb_q  <= val_b[WIDTH-1];
        op_q     <= ifun[1:0];
        set_cc_q <= set_cc;
        carry_q  <= (ifun == 4'd1);
        cnt_q    <= '0;
        acc_q    <= '0;
        val_e    <= '0;
      end else if (state_q == RUN) begin
        a_sh_q  <= a_sh_q >> NIB;
        b_sh_q  <= b_sh_q >> NIB;
        acc_q   <= result_c;
        carry_q <= cout_c;
        cnt_q   <= cnt_q + CNT_W'(1);
        if (last_c) begin
          val_e <= result_c;
          if (set_cc_q) begin
            zf <= (result_c == '0);
            sf <= result_c[WIDTH-1];
            of <= of_c;
          end
        end
      end
    end
  end

  // Branch / conditional-move condition from the registered flags.
  always_comb begin
    cnd = 1'b0;
    case (cond_fn)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = (sf ^ of) | zf;
      4'd2:    cnd = sf ^ of;
      4'd3:    cnd = zf;
      4'd4:    cnd = ~zf;
      4'd5:    cnd = ~(sf ^ of);
      4'd6:    cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_nibble_serial_exec_unit.sv
// Directed plus randomized bench for nibble_serial_exec_unit with a
// word-level reference model of results, flags and conditions.
module tb_nibble_serial_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  ifun;
  logic [63:0] val_a;
  logic [63:0] val_b;
  logic        set_cc;
  logic [3:0]  cond_fn;
  logic        ready;
  logic        done;
  logic        err;
  logic [63:0] val_e;
  logic        zf;
  logic        sf;
  logic        of;
  logic        cnd;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic        m_zf, m_sf, m_of, m_err;
  logic [63:0] m_val;

  nibble_serial_exec_unit #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ifun(ifun),
    .val_a(val_a), .val_b(val_b), .set_cc(set_cc), .cond_fn(cond_fn),
    .ready(ready), .done(done), .err(err), .val_e(val_e),
    .zf(zf), .sf(sf), .of(of), .cnd(cnd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_cnd(input logic [3:0] f);
    logic lt;
    lt = (m_sf != m_of);
    case (f)
      4'd0: return 1'b1;
      4'd1: return lt || m_zf;
      4'd2: return lt;
      4'd3: return m_zf;
      4'd4: return !m_zf;
      4'd5: return !lt;
      4'd6: return !lt && !m_zf;
      default: return 1'b0;
    endcase
  endfunction

  // Word-level result and flags using 65-bit sign-extended arithmetic.
  task automatic model_op(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                          input logic sc);
    logic [64:0] ext;
    logic        ovf;
    ext   = '0;
    ovf   = 1'b0;
    m_val = '0;
    m_err = (f > 4'd3);
    case (f)
      4'd0: begin ext = {a[63], a} + {b[63], b}; m_val = ext[63:0]; ovf = ext[64] ^ ext[63]; end
      4'd1: begin ext = {b[63], b} - {a[63], a}; m_val = ext[63:0]; ovf = ext[64] ^ ext[63]; end
      4'd2: m_val = a & b;
      4'd3: m_val = a ^ b;
      default: m_val = '0;
    endcase
    if (!m_err && sc) begin
      m_zf = (m_val == 64'd0);
      m_sf = m_val[63];
      m_of = ovf;
    end
  endtask

  task automatic check_cc(input string tag);
    check({tag, "_zf"}, zf, m_zf);
    check({tag, "_sf"}, sf, m_sf);
    check({tag, "_of"}, of, m_of);
  endtask

  task automatic check_cnd(input logic [3:0] f, input string tag);
    cond_fn = f;
    #1;
    check(tag, cnd, ref_cnd(f));
  endtask

  task automatic check_all_cnd(input string tag);
    for (int c = 0; c < 16; c++) begin
      cond_fn = 4'(c);
      step();
      check($sformatf("%s_cnd%0d", tag, c), cnd, ref_cnd(4'(c)));
    end
  endtask

  // One complete operation: drive, wait (bounded) for done, check everything.
  task automatic do_op(input string tag, input logic [3:0] f, input logic [63:0] a,
                       input logic [63:0] b, input logic sc);
    int k;
    check({tag, "_ready_in"}, ready, 1'b1);
    model_op(f, a, b, sc);
    ifun = f; val_a = a; val_b = b; set_cc = sc; start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    check({tag, "_latency"}, 64'(k), m_err ? 64'd0 : 64'd16);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_err"}, err, m_err);
    check({tag, "_val_e"}, val_e, m_val);
    check({tag, "_ready_run"}, ready, 1'b0);
    check_cc(tag);
    step();
    check({tag, "_done_drop"}, done, 1'b0);
    check({tag, "_ready_back"}, ready, 1'b1);
  endtask

  initial begin
    int dcount;
    logic [63:0] ra, rb;
    logic [3:0]  rf;

    rst_n = 1'b0; start = 1'b0; ifun = '0; val_a = '0; val_b = '0;
    set_cc = 1'b0; cond_fn = '0;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_err = 1'b0; m_val = '0;
    step(); step();
    rst_n = 1'b1;
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_val_e", val_e, 64'd0);
    check_cc("rst");
    step();

    // 1: add overflow into the sign bit.
    do_op("t1", 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    check("t1_lit", val_e, 64'h8000_0000_0000_0000);
    check_cnd(4'd2, "t1_cnd_l");

    // 2: equal subtract.
    do_op("t2", 4'd1, 64'd5, 64'd5, 1'b1);
    check_cnd(4'd3, "t2_cnd_e");
    check_cnd(4'd6, "t2_cnd_g");

    // 3: negative difference, then AND without CC update.
    do_op("t3a", 4'd1, 64'd3, 64'd2, 1'b1);
    check("t3a_lit", val_e, 64'hFFFF_FFFF_FFFF_FFFF);
    check_cnd(4'd2, "t3a_cnd_l");
    check_cnd(4'd5, "t3a_cnd_ge");
    do_op("t3b", 4'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b0);
    check("t3b_lit", val_e, 64'hF000_F000_F000_F000);
    check("t3b_sf_held", sf, 1'b1);

    // 6: illegal ifun leaves CC alone; a following add is legal.
    do_op("t6", 4'd7, 64'h1234, 64'h5678, 1'b1);
    check("t6_zf_held", zf, 1'b0);
    check("t6_sf_held", sf, 1'b1);
    do_op("t6b", 4'd0, 64'h0000_0000_1111_2222, 64'h0000_0000_3333_4444, 1'b0);

    // 4: xor to zero with start pulses during RUN and DONE.
    model_op(4'd3, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1);
    ifun = 4'd3; val_a = 64'h1234_5678_9ABC_DEF0; val_b = val_a; set_cc = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    dcount = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (done === 1'b1) dcount++;
      if (c == 16) begin
        check("t4_done_at16", done, 1'b1);
        check("t4_val_e", val_e, m_val);
        check_cc("t4");
      end
      if (c == 17) check("t4_ready_at17", ready, 1'b1);
      start = (c == 4 || c == 16);
    end
    check("t4_done_count", 64'(dcount), 64'd1);
    check("t4_ready_end", ready, 1'b1);

    // 5: reset in the middle of an add.
    ifun = 4'd0; val_a = 64'd1; val_b = 64'hFFFF_FFFF_FFFF_FFFF; set_cc = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    dcount = 0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (done === 1'b1) dcount++;
      if (c == 8) begin
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        check("t5_ready", ready, 1'b1);
        check("t5_val_e", val_e, 64'd0);
        check_cc("t5");
      end
      rst_n = (c == 7) ? 1'b0 : 1'b1;
    end
    check("t5_no_done", 64'(dcount), 64'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      rf = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      ra = {$urandom, $urandom};
      rb = (i % 5 == 0) ? ra : {$urandom, $urandom};
      if (i % 7 == 3) ra = 64'h8000_0000_0000_0000;
      do_op($sformatf("rnd%0d", i), rf, ra, rb, ($urandom_range(0, 3) != 0));
      if (i % 4 == 0) check_all_cnd($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
